// File: rtl/gpu_sprite_mem_responder.sv
// ============================================================================
// gpu_sprite_mem_responder: AXI-style read responder in front of a 1-cycle
// synchronous sprite RAM. Optional macro: GPU_SPRITE_MEM_RANGE_CHECK_EN.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gpu_sprite_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           axi_arvalid,
  output logic                           axi_arready,
  input  logic [31:0]                    axi_araddr,
  output logic                           axi_rvalid,
  input  logic                           axi_rready,
  output logic [31:0]                    axi_rdata,
  output logic [1:0]                     axi_rresp,
  output logic                           mem_en,
  output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr,
  input  logic [31:0]                    mem_rdata
);

  localparam int c_aw = $clog2(DEPTH_WORDS);
  localparam logic [1:0] c_okay   = 2'b00;
  localparam logic [1:0] c_slverr = 2'b10;

  logic [31:0] w_addr_off;
  logic [29:0] w_word_idx;
  logic        w_ar_hs;
  logic        w_range_err;
  logic        w_unused_lo;

  assign w_addr_off  = axi_araddr - ADDR_BASE;
  assign w_word_idx  = w_addr_off[31:2];
  assign w_ar_hs     = axi_arvalid && axi_arready;
  assign w_unused_lo = ^w_addr_off[1:0];

`ifdef GPU_SPRITE_MEM_RANGE_CHECK_EN
  localparam logic [29:0] c_depth = 30'(DEPTH_WORDS);
  assign w_range_err = (axi_araddr < ADDR_BASE) || (w_word_idx >= c_depth);
`else
  logic w_unused_hi;
  assign w_range_err = 1'b0;
  assign w_unused_hi = ^(w_word_idx >> c_aw);
`endif

  assign mem_en   = w_ar_hs && !w_range_err;
  assign mem_addr = w_word_idx[c_aw-1:0];

  // In-flight stage: RAM data for this request arrives one cycle later.
  logic        r_if_valid;
  logic        r_if_err;
  logic        r_arready;
  logic [1:0]  r_count;
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [33:0] r_fifo [3];

  logic        w_push;
  logic        w_pop;
  logic [33:0] w_push_entry;
  logic [33:0] w_head;
  logic [1:0]  w_count_next;
  logic        w_arready_next;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_push         = r_if_valid;
  assign w_pop          = axi_rvalid && axi_rready;
  assign w_push_entry   = r_if_err ? {32'h0, c_slverr} : {mem_rdata, c_okay};
  assign w_count_next   = r_count + 2'(w_push) - 2'(w_pop);
  // Credit covers both FIFO entries and the request still in flight.
  assign w_arready_next = ({1'b0, w_count_next} + 3'(w_ar_hs)) < 3'd3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_valid <= 1'b0;
      r_if_err   <= 1'b0;
      r_count    <= 2'd0;
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_arready  <= 1'b1;
    end else begin
      r_if_valid <= w_ar_hs;
      r_if_err   <= w_ar_hs && w_range_err;
      r_count    <= w_count_next;
      r_arready  <= w_arready_next;
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_push_entry;
  end

  // Outputs are forced idle while rst is high; r_arready is preset so the
  // block accepts in the very first cycle after reset releases.
  assign w_head      = r_fifo[r_rd_ptr];
  assign axi_arready = r_arready && !rst;
  assign axi_rvalid  = !rst && (r_count != 2'd0);
  assign axi_rdata   = axi_rvalid ? w_head[33:2] : 32'h0;
  assign axi_rresp   = axi_rvalid ? w_head[1:0]  : 2'b00;

endmodule

`default_nettype wire

// File: doc/gpu_sprite_mem_responder.md
GPU_SPRITE_MEM_RESPONDER -- requirements
Module: gpu_sprite_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0000_0000, byte address of sprite-memory word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 4096, number of 32-bit words; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port axi_arvalid, input, 1, read-address valid from the GPU memory stage.
REQ-006 SHALL have port axi_arready, output, 1, read-address accept.
REQ-007 SHALL have port axi_araddr, input, 32, read byte address.
REQ-008 SHALL have port axi_rvalid, output, 1, read-data valid.
REQ-009 SHALL have port axi_rready, input, 1, read-data accept.
REQ-010 SHALL have port axi_rdata, output, 32, read data.
REQ-011 SHALL have port axi_rresp, output, 2, response code: 2'b00 OKAY, 2'b10 SLVERR.
REQ-012 SHALL have port mem_en, output, 1, synchronous-RAM read enable.
REQ-013 SHALL have port mem_addr, output, $clog2(DEPTH_WORDS), RAM word index.
REQ-014 SHALL have port mem_rdata, input, 32, RAM data, valid exactly one cycle after mem_en.

Function
REQ-015 An AR handshake is a cycle with axi_arvalid && axi_arready; an R handshake is a cycle with axi_rvalid && axi_rready.
REQ-016 Word index = (axi_araddr - ADDR_BASE) >> 2; axi_araddr[1:0] are ignored, and unaligned addresses receive OKAY.
REQ-017 mem_en is combinational, equal to the AR handshake (gated per REQ-029); mem_addr is the low $clog2(DEPTH_WORDS) bits of the word index.
REQ-018 A one-entry in-flight stage records valid and error flag on each AR handshake; the next cycle pushes {mem_rdata, rresp} into a 3-entry response FIFO.
REQ-019 Latency: AR handshake in cycle t, axi_rvalid high in cycle t+2 at the earliest, when the FIFO was empty.
REQ-020 axi_rvalid = FIFO not empty; axi_rdata/axi_rresp = FIFO head; both are held stable while axi_rvalid && !axi_rready.
REQ-021 The FIFO pops on an R handshake; simultaneous push and pop leaves the count unchanged.
REQ-022 axi_arready is registered, high in the next cycle iff next in-flight count + next FIFO count < 3; the FIFO never overflows.
REQ-023 With axi_arvalid and axi_rready held high, the block sustains one AR and one R handshake per cycle with no bubbles after the first two cycles.
REQ-024 With axi_rready held low, exactly 3 requests are accepted, then axi_arready stays low until a pop.
REQ-025 Responses are returned strictly in request order; there is no reordering and no drop.
REQ-026 axi_arready does not combinationally depend on axi_arvalid or axi_rready.

Reset
REQ-027 While rst is high: axi_arready=0, axi_rvalid=0, axi_rdata=0, axi_rresp=0, mem_en=0, in-flight stage and FIFO emptied.
REQ-028 Reset mid-transaction discards all pending responses; axi_arready returns high in the first cycle after rst falls.

Configuration
REQ-029 Macro GPU_SPRITE_MEM_RANGE_CHECK_EN defined: an address below ADDR_BASE or a word index >= DEPTH_WORDS is accepted with mem_en=0 and answered in order with rdata 32'h0 and rresp 2'b10.
REQ-030 Macro GPU_SPRITE_MEM_RANGE_CHECK_EN undefined: no check is made, the index wraps modulo DEPTH_WORDS, and rresp is always 2'b00.

Verification
REQ-031 Single read at ADDR_BASE+8, RAM word2=32'hCAFE_F00D, rready=1 -> rvalid in cycle t+2, rdata=32'hCAFE_F00D, rresp=00.
REQ-032 Reads of addresses 0,4,8,...,60 back-to-back with rready=1 -> 16 ordered R beats on consecutive cycles, arready never low after the start.
REQ-033 rready=0 with 5 requests offered -> 3 accepted, arready low; rready raised -> 3 beats in order, then the remaining 2 are accepted.
REQ-034 With the macro defined, DEPTH_WORDS=4096, read at ADDR_BASE+16384 -> mem_en stays 0, rdata=0, rresp=10; without the macro -> word 0 returned, rresp=00.
REQ-035 rst pulsed with 2 responses pending and rready=0 -> rvalid=0 the next cycle and no stale beat afterwards; a new read returns the correct data.
REQ-036 Unaligned read at ADDR_BASE+7 -> the word-1 data is returned with rresp=00.
